// File: rtl/serial_frame_rx.sv
// ---------------------------------------------------------------------------
// serial_frame_rx
// Receive-side deserializer for the MSDAP stereo serial interface. DCLK,
// Frame, InputL and InputR are oversampled in the SCLK domain. Each falling
// edge of the synchronized DCLK samples one bit of the left and right words,
// most significant bit first. Every complete 16-bit pair is presented in
// parallel together with a one-cycle strobe.
//
// Ports
//   SCLK       system clock, the only clock
//   Reset_n    asynchronous active-low reset
//   DCLK       serial data clock, asynchronous to SCLK, may stall low
//   Frame      high during the MSB bit period of each word
//   InputL/R   left / right serial data, MSB first
//   Enable     receiver enable; low aborts any partial word
//   DataL/R    last complete left / right word
//   WordValid  one-SCLK pulse when DataL/DataR update
//   FrameErr   one-SCLK pulse when Frame arrives in the middle of a word
//   Busy       high while a word is partially received
// ---------------------------------------------------------------------------
module serial_frame_rx #(
    parameter int WORD_W      = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic              SCLK,
    input  logic              Reset_n,
    input  logic              DCLK,
    input  logic              Frame,
    input  logic              InputL,
    input  logic              InputR,
    input  logic              Enable,
    output logic [WORD_W-1:0] DataL,
    output logic [WORD_W-1:0] DataR,
    output logic              WordValid,
    output logic              FrameErr,
    output logic              Busy
);

    localparam int CNT_W = $clog2(WORD_W) + 1;
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORD_W - 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RECV = 1'b1
    } state_t;

    logic [SYNC_STAGES-1:0] dclk_sync_r;
    logic [SYNC_STAGES-1:0] frame_sync_r;
    logic [SYNC_STAGES-1:0] inl_sync_r;
    logic [SYNC_STAGES-1:0] inr_sync_r;
    logic                   dclk_prev_r;

    state_t            state_r,   state_nxt_s;
    logic [CNT_W-1:0]  cnt_r,     cnt_nxt_s;
    logic [WORD_W-1:0] shl_r,     shl_nxt_s;
    logic [WORD_W-1:0] shr_r,     shr_nxt_s;
    logic [WORD_W-1:0] data_l_r,  data_l_nxt_s;
    logic [WORD_W-1:0] data_r_r,  data_r_nxt_s;
    logic              valid_r,   valid_nxt_s;
    logic              err_r,     err_nxt_s;
    logic              busy_r;

    logic              dclk_s, frame_s, inl_s, inr_s, sample_s;
    logic [WORD_W-1:0] shl_shift_s, shr_shift_s;
    logic [WORD_W-1:0] shl_load_s,  shr_load_s;

    // All four lines take the same path, so DCLK and its data stay aligned.
    assign dclk_s   = dclk_sync_r[SYNC_STAGES-1];
    assign frame_s  = frame_sync_r[SYNC_STAGES-1];
    assign inl_s    = inl_sync_r[SYNC_STAGES-1];
    assign inr_s    = inr_sync_r[SYNC_STAGES-1];
    // The transmitter changes data on DCLK rise, so the fall is mid-bit.
    assign sample_s = dclk_prev_r & ~dclk_s;

    // The shift registers fill from the LSB. After WORD_W bits, the first
    // bit (the MSB) has moved into bit WORD_W-1.
    assign shl_shift_s = {shl_r[WORD_W-2:0], inl_s};
    assign shr_shift_s = {shr_r[WORD_W-2:0], inr_s};
    assign shl_load_s  = {{(WORD_W-1){1'b0}}, inl_s};
    assign shr_load_s  = {{(WORD_W-1){1'b0}}, inr_s};

    // Input synchronizers and the DCLK edge-detect history.
    always_ff @(posedge SCLK or negedge Reset_n) begin
        if (!Reset_n) begin
            dclk_sync_r  <= {SYNC_STAGES{1'b0}};
            frame_sync_r <= {SYNC_STAGES{1'b0}};
            inl_sync_r   <= {SYNC_STAGES{1'b0}};
            inr_sync_r   <= {SYNC_STAGES{1'b0}};
            dclk_prev_r  <= 1'b0;
        end else begin
            dclk_sync_r  <= {dclk_sync_r[SYNC_STAGES-2:0],  DCLK};
            frame_sync_r <= {frame_sync_r[SYNC_STAGES-2:0], Frame};
            inl_sync_r   <= {inl_sync_r[SYNC_STAGES-2:0],   InputL};
            inr_sync_r   <= {inr_sync_r[SYNC_STAGES-2:0],   InputR};
            dclk_prev_r  <= dclk_s;
        end
    end

    // Next-state, word assembly and output-strobe decode.
    always_comb begin
        state_nxt_s  = state_r;
        cnt_nxt_s    = cnt_r;
        shl_nxt_s    = shl_r;
        shr_nxt_s    = shr_r;
        data_l_nxt_s = data_l_r;
        data_r_nxt_s = data_r_r;
        valid_nxt_s  = 1'b0;
        err_nxt_s    = 1'b0;
        if (!Enable) begin
            // Drop any partial word. DataL/DataR keep the last good pair.
            state_nxt_s = S_IDLE;
            cnt_nxt_s   = CNT_ZERO;
            shl_nxt_s   = {WORD_W{1'b0}};
            shr_nxt_s   = {WORD_W{1'b0}};
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (sample_s && frame_s) begin
                        shl_nxt_s   = shl_load_s;
                        shr_nxt_s   = shr_load_s;
                        cnt_nxt_s   = CNT_ONE;
                        state_nxt_s = S_RECV;
                    end else begin
                        state_nxt_s = S_IDLE;
                    end
                end
                S_RECV: begin
                    if (sample_s && frame_s) begin
                        // Frame arrived mid-word: abandon the partial word
                        // and treat this bit as the MSB of a new one.
                        err_nxt_s = 1'b1;
                        shl_nxt_s = shl_load_s;
                        shr_nxt_s = shr_load_s;
                        cnt_nxt_s = CNT_ONE;
                    end else if (sample_s) begin
                        shl_nxt_s = shl_shift_s;
                        shr_nxt_s = shr_shift_s;
                        if (cnt_r == CNT_LAST) begin
                            data_l_nxt_s = shl_shift_s;
                            data_r_nxt_s = shr_shift_s;
                            valid_nxt_s  = 1'b1;
                            cnt_nxt_s    = CNT_ZERO;
                            state_nxt_s  = S_IDLE;
                        end else begin
                            cnt_nxt_s = cnt_r + CNT_ONE;
                        end
                    end else begin
                        // DCLK idle or stalled: hold position in the word.
                        state_nxt_s = S_RECV;
                    end
                end
                default: begin
                    state_nxt_s = S_IDLE;
                    cnt_nxt_s   = CNT_ZERO;
                end
            endcase
        end
    end

    // Receiver state and registered outputs.
    always_ff @(posedge SCLK or negedge Reset_n) begin
        if (!Reset_n) begin
            state_r  <= S_IDLE;
            cnt_r    <= CNT_ZERO;
            shl_r    <= {WORD_W{1'b0}};
            shr_r    <= {WORD_W{1'b0}};
            data_l_r <= {WORD_W{1'b0}};
            data_r_r <= {WORD_W{1'b0}};
            valid_r  <= 1'b0;
            err_r    <= 1'b0;
            busy_r   <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            cnt_r    <= cnt_nxt_s;
            shl_r    <= shl_nxt_s;
            shr_r    <= shr_nxt_s;
            data_l_r <= data_l_nxt_s;
            data_r_r <= data_r_nxt_s;
            valid_r  <= valid_nxt_s;
            err_r    <= err_nxt_s;
            busy_r   <= (state_nxt_s == S_RECV);
        end
    end

    assign DataL     = data_l_r;
    assign DataR     = data_r_r;
    assign WordValid = valid_r;
    assign FrameErr  = err_r;
    assign Busy      = busy_r;

endmodule
